// File: rtl/io_output_port_if.sv
// CPU/device bus of the output port: CPU write/status/interrupt signals
// and the device-side strobe/ack handshake.
interface io_output_port_if;
    logic       switch;
    logic       cpu_wr;
    logic [7:0] cpu_data;
    logic       cpu_stat_rd;
    logic [7:0] status;
    logic       irq;
    logic       irq_ack;
    logic [7:0] dev_data;
    logic       dev_strb;
    logic       dev_ack;

    // Port side: consumes CPU writes and device acks, drives the device.
    modport slave (
        input  switch, cpu_wr, cpu_data, cpu_stat_rd, irq_ack, dev_ack,
        output status, irq, dev_data, dev_strb
    );

    // CPU + device side as seen by whoever talks to the port.
    modport master (
        output switch, cpu_wr, cpu_data, cpu_stat_rd, irq_ack, dev_ack,
        input  status, irq, dev_data, dev_strb
    );
endinterface

// File: rtl/io_output_port.sv
// Output port: CPU byte FIFO drained to a device over a 4-phase strobe/ack
// handshake, with a polling status word and a drain interrupt.
module io_output_port #(
    parameter int DEPTH     = 4,
    parameter int SETUP_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    io_output_port_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(SETUP_CYC + 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop, load;
    logic          ovf;
    logic [TW-1:0] timer;
    state_t        state, state_nxt;
    logic [7:0]    dev_data_q;
    logic          dev_strb_q;
    logic          irq_pend, pend_nxt, irq_q;
    logic [31:0]   cnt_w;
    logic [2:0]    cnt3;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // A write while full is dropped even if the head pops in the same cycle.
    assign push  = bus.cpu_wr && !full;

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.cpu_data;
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a new overflow outranks a status-read clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        ovf <= 1'b0;
        else if (bus.cpu_wr && full)    ovf <= 1'b1;
        else if (bus.cpu_stat_rd)       ovf <= 1'b0;
    end

    // Handshake FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state plus the load/pop strobes that move bytes out of the FIFO.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE:    if (!empty) begin
                         load      = 1'b1;
                         state_nxt = SETUP;
                     end
            SETUP:   if (timer == '0) state_nxt = STROBE;
            STROBE:  if (bus.dev_ack) state_nxt = RELEASE;
            RELEASE: if (!bus.dev_ack) begin
                         pop       = 1'b1;
                         state_nxt = IDLE;
                     end
            default: state_nxt = IDLE;
        endcase
    end

    // Setup timer: counts down the data-to-strobe hold after each load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   timer <= '0;
        else if (load)                             timer <= TW'(SETUP_CYC - 1);
        else if (state == SETUP && timer != '0)    timer <= timer - 1'b1;
    end

    // Device outputs: data latched on load, strobe registered off next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dev_data_q <= 8'h00;
            dev_strb_q <= 1'b0;
        end else begin
            if (load) dev_data_q <= mem[rd_ptr];
            dev_strb_q <= (state_nxt == STROBE);
        end
    end

    // Pending interrupt: set by the draining pop, which beats a same-cycle ack.
    always_comb begin
        pend_nxt = irq_pend;
        if (!bus.switch)                              pend_nxt = 1'b0;
        else if (pop && count == CW'(1) && !push)     pend_nxt = 1'b1;
        else if (bus.irq_ack || push)                 pend_nxt = 1'b0;
    end

    // irq is the registered, mode-gated view of the pending flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_pend <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_pend <= pend_nxt;
            irq_q    <= pend_nxt & bus.switch;
        end
    end

    assign cnt_w = 32'(count);
    assign cnt3  = (cnt_w > 32'd7) ? 3'd7 : cnt_w[2:0];

    assign bus.status   = {ovf, empty, full, (state != IDLE), 1'b0, cnt3};
    assign bus.irq      = irq_q;
    assign bus.dev_data = dev_data_q;
    assign bus.dev_strb = dev_strb_q;
endmodule
